// File: rtl/usb_rx_pkg.sv
// Shared constants and types for the USB 1.1 receive path.
package usb_rx_pkg;
  localparam int CLKS_PER_BIT = 8;
  localparam int SAMPLE_PHASE = 4;
  localparam int STUFF_LEN    = 6;
  localparam int ONES_W       = $clog2(STUFF_LEN + 1);

  localparam logic [7:0] SYNC_BYTE = 8'h80;

  typedef logic [3:0] phase_t;
endpackage

// File: rtl/flex_counter.sv
// Parameterised counter running 1..rollover_val; clear and reset both return it to 1.
module flex_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag
);
  localparam logic [NUM_CNT_BITS-1:0] ONE = NUM_CNT_BITS'(1);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)
      count_out <= ONE;
    else if (clear)
      count_out <= ONE;
    else if (count_enable)
      count_out <= (count_out == rollover_val) ? ONE : count_out + ONE;
  end

  assign rollover_flag = (count_out == rollover_val);
endmodule

// File: rtl/rx_bit_timer.sv
// USB receive bit timing: phase recovery, stuffed-bit removal, shift and byte strobes.
module rx_bit_timer
  import usb_rx_pkg::*;
(
  input  logic clk,
  input  logic n_rst,
  input  logic d_edge,
  input  logic rcving,
  input  logic d_orig,
  output logic shift_en,
  output logic byte_rcvd,
  output logic stuff_err
);
  phase_t              phase;
  logic                phase_wrap;
  logic [2:0]          bit_cnt;
  logic [ONES_W-1:0]   ones_cnt;
  logic                byte_rcvd_q;
  logic                sample;
  logic                stuff_pend;

  // Any line transition re-centres the sample point on the incoming bit.
  flex_counter #(.NUM_CNT_BITS($bits(phase_t))) u_phase (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (~rcving | d_edge),
    .count_enable (rcving),
    .rollover_val (phase_t'(CLKS_PER_BIT)),
    .count_out    (phase),
    .rollover_flag(phase_wrap)
  );

  assign sample     = rcving && (phase == phase_t'(SAMPLE_PHASE));
  assign stuff_pend = (ones_cnt == ONES_W'(STUFF_LEN));
  assign shift_en   = sample && !stuff_pend;
  assign stuff_err  = sample && stuff_pend && d_orig;
  assign byte_rcvd  = byte_rcvd_q;

  // ones_cnt deliberately survives byte boundaries: stuffing spans bytes.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      bit_cnt     <= '0;
      ones_cnt    <= '0;
      byte_rcvd_q <= 1'b0;
    end else if (!rcving) begin
      bit_cnt     <= '0;
      ones_cnt    <= '0;
      byte_rcvd_q <= 1'b0;
    end else begin
      byte_rcvd_q <= 1'b0;
      if (sample) begin
        if (stuff_pend) begin
          ones_cnt <= '0;
        end else begin
          ones_cnt <= d_orig ? ones_cnt + 1'b1 : '0;
          bit_cnt  <= bit_cnt + 1'b1;
          if (bit_cnt == 3'd7)
            byte_rcvd_q <= 1'b1;
        end
      end
    end
  end

  a_phase_wrap: assert property (@(posedge clk) disable iff (!n_rst)
    phase_wrap |=> (phase == phase_t'(1)));
endmodule

// File: tb/tb_rx_bit_timer.sv
// Directed bench for rx_bit_timer: SYNC, stuffing, stuff error, drift, rcving drop, async reset.
module tb_rx_bit_timer;
  logic clk = 1'b0;
  logic n_rst, d_edge, rcving, d_orig;
  logic shift_en, byte_rcvd, stuff_err;

  int total = 0, bad = 0;
  int cyc = 0, n_shift = 0, n_byte = 0, n_err = 0;
  int last_shift_cyc = -1, last_byte_cyc = -1;
  int b0, s0;

  rx_bit_timer dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .d_edge   (d_edge),
    .rcving   (rcving),
    .d_orig   (d_orig),
    .shift_en (shift_en),
    .byte_rcvd(byte_rcvd),
    .stuff_err(stuff_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock: drive on the falling edge, sample 1 time unit later.
  task automatic drive_cyc(input logic rcv, input logic edg, input logic d,
                           output logic sh, output logic br, output logic se);
    @(negedge clk);
    rcving = rcv; d_edge = edg; d_orig = d;
    #1;
    sh = shift_en; br = byte_rcvd; se = stuff_err;
    if (sh) begin n_shift++; last_shift_cyc = cyc; end
    if (br) begin n_byte++;  last_byte_cyc  = cyc; end
    if (se) n_err++;
    cyc++;
  endtask

  // One USB bit slot; decoded 0 means a line transition at offset 0.
  task automatic send_bit(input logic d, input int len, input logic start_rcv,
                          input int exp_shift, input int exp_err);
    logic sh, br, se;
    int sh_n = 0, sh_off = -1, er_n = 0, er_off = -1;
    for (int o = 0; o < len; o++) begin
      drive_cyc((o == 0) ? start_rcv : 1'b1, (o == 0) && !d, d, sh, br, se);
      if (sh) begin sh_n++; sh_off = o; end
      if (se) begin er_n++; er_off = o; end
    end
    chk("shift_cnt", sh_n, exp_shift);
    if (exp_shift != 0) chk("shift_off", sh_off, 4);
    chk("err_cnt", er_n, exp_err);
    if (exp_err != 0) chk("err_off", er_off, 4);
  endtask

  task automatic idle(input int n);
    logic sh, br, se;
    for (int i = 0; i < n; i++) drive_cyc(1'b0, 1'b0, 1'b0, sh, br, se);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic sh, br, se;
    logic [7:0] sync_b;
    sync_b = 8'h80;
    n_rst = 1'b0; rcving = 1'b1; d_edge = 1'b1; d_orig = 1'b1;
    #23;
    chk("rst_shift", int'(shift_en), 0);
    chk("rst_byte",  int'(byte_rcvd), 0);
    chk("rst_err",   int'(stuff_err), 0);
    @(negedge clk); rcving = 1'b0; d_edge = 1'b0; d_orig = 1'b0;
    @(negedge clk); n_rst = 1'b1;
    idle(3);
    chk("idle_shift", n_shift, 0);

    // SYNC, LSB first; rcving rises the cycle after the first edge
    for (int i = 0; i < 8; i++) send_bit(sync_b[i], 8, (i == 0) ? 1'b0 : 1'b1, 1, 0);
    chk("sync_bytes", n_byte, 1);
    chk("sync_byte_lat", last_byte_cyc - last_shift_cyc, 1);
    chk("sync_shifts", n_shift, 8);

    // 0xFE with a stuffed 0 after six 1s, then 0x01
    b0 = n_byte; s0 = n_shift;
    send_bit(1'b0, 8, 1'b1, 1, 0);
    for (int i = 0; i < 6; i++) send_bit(1'b1, 8, 1'b1, 1, 0);
    send_bit(1'b0, 8, 1'b1, 0, 0);
    send_bit(1'b1, 8, 1'b1, 1, 0);
    chk("b1_bytes", n_byte - b0, 1);
    chk("b1_byte_lat", last_byte_cyc - last_shift_cyc, 1);
    send_bit(1'b1, 8, 1'b1, 1, 0);
    for (int i = 0; i < 7; i++) send_bit(1'b0, 8, 1'b1, 1, 0);
    chk("stuff_bytes", n_byte - b0, 2);
    chk("stuff_shifts", n_shift - s0, 16);
    chk("stuff_no_err", n_err, 0);

    // Seventh consecutive 1 in the stuff slot
    b0 = n_byte;
    for (int i = 0; i < 6; i++) send_bit(1'b1, 8, 1'b1, 1, 0);
    send_bit(1'b1, 8, 1'b1, 0, 1);
    send_bit(1'b0, 8, 1'b1, 1, 0);
    send_bit(1'b0, 8, 1'b1, 1, 0);
    chk("err_total", n_err, 1);
    chk("err_bytes", n_byte - b0, 1);

    // Drift: alternating 7 and 9 clk bits
    b0 = n_byte; s0 = n_shift;
    for (int i = 0; i < 8; i++) send_bit(1'b0, (i % 2 == 0) ? 7 : 9, 1'b1, 1, 0);
    chk("drift_shifts", n_shift - s0, 8);
    chk("drift_bytes", n_byte - b0, 1);

    // Partial byte then rcving drop; next packet restarts bit count
    b0 = n_byte;
    for (int i = 0; i < 5; i++) send_bit(1'b0, 8, 1'b1, 1, 0);
    idle(6);
    chk("drop_bytes", n_byte - b0, 0);
    for (int i = 0; i < 7; i++) send_bit(1'b0, 8, (i == 0) ? 1'b0 : 1'b1, 1, 0);
    chk("pkt2_early", n_byte - b0, 0);
    send_bit(1'b0, 8, 1'b1, 1, 0);
    chk("pkt2_bytes", n_byte - b0, 1);
    chk("pkt2_byte_lat", last_byte_cyc - last_shift_cyc, 1);

    // Async reset landing on a sample cycle mid-byte
    send_bit(1'b0, 8, 1'b1, 1, 0);
    send_bit(1'b0, 8, 1'b1, 1, 0);
    drive_cyc(1'b1, 1'b1, 1'b0, sh, br, se);
    for (int i = 0; i < 3; i++) drive_cyc(1'b1, 1'b0, 1'b0, sh, br, se);
    @(negedge clk);
    rcving = 1'b1; d_edge = 1'b0; d_orig = 1'b1;
    #1;
    chk("pre_rst_shift", int'(shift_en), 1);
    n_rst = 1'b0;
    #1;
    chk("arst_shift", int'(shift_en), 0);
    chk("arst_byte",  int'(byte_rcvd), 0);
    chk("arst_err",   int'(stuff_err), 0);
    @(negedge clk); @(negedge clk);
    n_rst = 1'b1;
    #1;
    // phase restarts at 1, so with no edge the 4th cycle from release samples
    begin
      int off = -1;
      s0 = n_shift; b0 = n_byte;
      if (shift_en) off = 0;
      n_shift += int'(shift_en);
      for (int i = 1; i < 4; i++) begin
        drive_cyc(1'b1, 1'b0, 1'b0, sh, br, se);
        if (sh) off = i;
      end
      chk("post_rst_off", off, 3);
    end
    for (int i = 0; i < 7; i++) send_bit(1'b0, 8, 1'b1, 1, 0);
    chk("post_rst_shifts", n_shift - s0, 8);
    chk("post_rst_bytes", n_byte - b0, 1);
    chk("post_rst_lat", last_byte_cyc - last_shift_cyc, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
